// File: rtl/vga_timing_gen.sv
// Raster timing master for 640x480@60 VGA: coordinates, blank, syncs and strobes.
// Optional sync alignment delay line enabled by defining VGA_SYNC_ALIGN_EN.
module vga_timing_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int CLK_DIV     = 1,
  parameter int ALIGN_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       pix_tick,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_MAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_MAX   = 10'(V_TOTAL - 1);
  localparam logic [3:0]  DIV_MAX = 4'(CLK_DIV - 1);
  // 11-bit bounds so a 1024-wide total still compares correctly
  localparam logic [10:0] H_VIS   = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS   = 11'(V_VISIBLE);
  localparam logic [10:0] HS_LO   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_HI   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_LO   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_HI   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [3:0] r_div;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_blank;
  logic       r_hs;
  logic       r_vs;
  logic       r_pix;
  logic       r_line;
  logic       r_frame;
  logic [7:0] r_fcnt;

  logic       w_update;
  logic       w_x_wrap;
  logic [9:0] w_x_next;
  logic [9:0] w_y_next;
  logic       w_blank_next;
  logic       w_hs_next;
  logic       w_vs_next;
  logic       w_line_next;
  logic       w_frame_next;

  always_comb begin
    w_update = (r_div == DIV_MAX);
    w_x_wrap = (r_x == H_MAX);
    if (w_x_wrap) begin
      w_x_next = 10'd0;
      if (r_y == V_MAX) begin
        w_y_next = 10'd0;
      end else begin
        w_y_next = r_y + 10'd1;
      end
    end else begin
      w_x_next = r_x + 10'd1;
      w_y_next = r_y;
    end
    w_blank_next = ({1'b0, w_x_next} < H_VIS) && ({1'b0, w_y_next} < V_VIS);
    w_hs_next    = !(({1'b0, w_x_next} >= HS_LO) && ({1'b0, w_x_next} < HS_HI));
    w_vs_next    = !(({1'b0, w_y_next} >= VS_LO) && ({1'b0, w_y_next} < VS_HI));
    w_line_next  = (w_x_next == 10'd0);
    w_frame_next = (w_x_next == 10'd0) && (w_y_next == 10'd0);
  end

  // Reset parks the raster on the last pixel so the first update lands on (0,0).
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_div   <= 4'd0;
      r_x     <= H_MAX;
      r_y     <= V_MAX;
      r_blank <= 1'b0;
      r_hs    <= 1'b1;
      r_vs    <= 1'b1;
      r_pix   <= 1'b0;
      r_line  <= 1'b0;
      r_frame <= 1'b0;
      r_fcnt  <= 8'd0;
    end else if (w_update) begin
      r_div   <= 4'd0;
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_blank <= w_blank_next;
      r_hs    <= w_hs_next;
      r_vs    <= w_vs_next;
      r_pix   <= 1'b1;
      r_line  <= w_line_next;
      r_frame <= w_frame_next;
      if (w_frame_next) begin
        r_fcnt <= r_fcnt + 8'd1;
      end
    end else begin
      r_div   <= r_div + 4'd1;
      r_pix   <= 1'b0;
      r_line  <= 1'b0;
      r_frame <= 1'b0;
    end
  end

`ifdef VGA_SYNC_ALIGN_EN
  logic [ALIGN_DELAY-1:0] r_hs_dly;
  logic [ALIGN_DELAY-1:0] r_vs_dly;

  // Shifts every vga_clk to match the renderers' ROM plus RGB register latency.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_hs_dly <= {ALIGN_DELAY{1'b1}};
      r_vs_dly <= {ALIGN_DELAY{1'b1}};
    end else begin
      r_hs_dly[0] <= r_hs;
      r_vs_dly[0] <= r_vs;
      for (int i = 1; i < ALIGN_DELAY; i++) begin
        r_hs_dly[i] <= r_hs_dly[i-1];
        r_vs_dly[i] <= r_vs_dly[i-1];
      end
    end
  end

  assign hs = r_hs_dly[ALIGN_DELAY-1];
  assign vs = r_vs_dly[ALIGN_DELAY-1];
`else
  assign hs = r_hs;
  assign vs = r_vs;
`endif

  assign DrawX       = r_x;
  assign DrawY       = r_y;
  assign blank       = r_blank;
  assign pix_tick    = r_pix;
  assign line_start  = r_line;
  assign frame_start = r_frame;
  assign frame_count = r_fcnt;

endmodule
